// File: rtl/shake_msg_serializer_if.sv
// ---------------------------------------------------------------------------
// shake_msg_serializer_if
//
// Bundles the byte-stream input, the accumulator handshake and the serial
// chunk output of shake_msg_serializer.
//
// Handshake semantics (the one place they are written down):
//   Byte stream: a byte moves from producer to serializer on a rising clk edge
//   where s_valid && s_ready. s_data and s_last are only meaningful while
//   s_valid is high. s_ready is a decode of registered state and never depends
//   combinationally on s_valid. The serializer tolerates s_valid toggling, so
//   a producer may withdraw a byte that has not yet been taken.
//   Accumulator: acc_block_ready is level-sampled while the serializer waits
//   between blocks. Any cycle in which it is high counts as the
//   acknowledgement. Outside that wait it is ignored.
//   Zero-length message: empty_msg is a single-cycle pulse that is only
//   honoured while the serializer is idle.
//
// Signals:
//   s_valid, s_data[7:0], s_last, s_ready : message byte stream
//   empty_msg                             : zero-length message pulse
//   acc_block_ready                       : accumulator finished its block
//   acc_start                             : pulse, a new block begins
//   enable_2bit, serial_out[1:0]          : 2-bit chunk stream, LSB pair first
//   serial_end                            : pulse, no more data in this block
//   final_chunk                           : level, current block is the last
//   msg_done                              : pulse, final block acknowledged
//   busy                                  : serializer not idle
//
// Modports:
//   master : the message producer and accumulator side
//   slave  : the serializer side
// ---------------------------------------------------------------------------
interface shake_msg_serializer_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;
  logic       empty_msg;
  logic       acc_block_ready;
  logic       acc_start;
  logic       enable_2bit;
  logic [1:0] serial_out;
  logic       serial_end;
  logic       final_chunk;
  logic       msg_done;
  logic       busy;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    output empty_msg,
    output acc_block_ready,
    input  s_ready,
    input  acc_start,
    input  enable_2bit,
    input  serial_out,
    input  serial_end,
    input  final_chunk,
    input  msg_done,
    input  busy
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    input  empty_msg,
    input  acc_block_ready,
    output s_ready,
    output acc_start,
    output enable_2bit,
    output serial_out,
    output serial_end,
    output final_chunk,
    output msg_done,
    output busy
  );
endinterface

// File: rtl/shake_msg_serializer.sv
// ---------------------------------------------------------------------------
// shake_msg_serializer
//
// Upstream feeder for the SHAKE256 message accumulator. Message bytes arrive
// on a valid/ready stream. Each byte is emitted as four 2-bit chunks, starting
// with the least significant pair. Chunks are framed into blocks of
// RATE_BYTES bytes:
//   - every block starts with a one-cycle acc_start pulse
//   - a block that ends the message (not completely full) ends with a
//     one-cycle serial_end pulse and raises final_chunk
//   - a completely full block never carries serial_end; the serializer
//     waits for the accumulator and continues with the next block
//   - when the message ends exactly on a block boundary (or is empty) an
//     extra block with no data is issued: acc_start, then serial_end
//     immediately, with final_chunk raised
// Between blocks the serializer waits for acc_block_ready. Once the final
// block is acknowledged it pulses msg_done and returns to idle.
//
// Parameters:
//   RATE_BYTES : bytes per rate block, legal range 2..255 (136 for SHAKE256)
//
// Ports:
//   clk       : clock, all logic on the rising edge
//   reset     : asynchronous, active-high
//   bus       : shake_msg_serializer_if slave modport (stream, handshake,
//               chunk output and status)
//   dbg_state : current FSM state encoding for observation
//
// All outputs are decodes of registered state. There is no combinational
// path from any input to any output.
// ---------------------------------------------------------------------------
module shake_msg_serializer #(
  parameter int RATE_BYTES = 136
) (
  input  logic                    clk,
  input  logic                    reset,
  shake_msg_serializer_if.slave   bus,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    SHIFT    = 3'd2,
    END_BLK  = 3'd3,
    WAIT_ACK = 3'd4
  } state_t;

  localparam logic [7:0] RATE_CNT = 8'(RATE_BYTES);

  state_t     state;
  state_t     state_nxt;

  logic [7:0] hold_byte;
  logic [7:0] hold_byte_nxt;
  logic       held;
  logic       held_nxt;
  logic       held_last;
  logic       held_last_nxt;
  logic [1:0] dibit_cnt;
  logic [1:0] dibit_cnt_nxt;
  logic [7:0] byte_cnt;
  logic [7:0] byte_cnt_nxt;
  logic       pad_pending;
  logic       pad_pending_nxt;
  logic       final_q;
  logic       final_nxt;
  logic       msg_done_q;
  logic       msg_done_nxt;

  // Byte count after the byte currently being emitted has gone out.
  logic [7:0] byte_cnt_inc;
  assign byte_cnt_inc = byte_cnt + 8'd1;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      hold_byte   <= 8'h00;
      held        <= 1'b0;
      held_last   <= 1'b0;
      dibit_cnt   <= 2'd0;
      byte_cnt    <= 8'd0;
      pad_pending <= 1'b0;
      final_q     <= 1'b0;
      msg_done_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_byte   <= hold_byte_nxt;
      held        <= held_nxt;
      held_last   <= held_last_nxt;
      dibit_cnt   <= dibit_cnt_nxt;
      byte_cnt    <= byte_cnt_nxt;
      pad_pending <= pad_pending_nxt;
      final_q     <= final_nxt;
      msg_done_q  <= msg_done_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and register update logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt       = state;
    hold_byte_nxt   = hold_byte;
    held_nxt        = held;
    held_last_nxt   = held_last;
    dibit_cnt_nxt   = dibit_cnt;
    byte_cnt_nxt    = byte_cnt;
    pad_pending_nxt = pad_pending;
    final_nxt       = final_q;
    msg_done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        // A real byte wins over a simultaneous zero-length pulse.
        if (bus.s_valid) begin
          state_nxt = START;
        end else if (bus.empty_msg) begin
          state_nxt       = START;
          pad_pending_nxt = 1'b1;
        end
      end

      START: begin
        byte_cnt_nxt = 8'd0;
        // A padding-only block carries no data and closes immediately.
        state_nxt    = pad_pending ? END_BLK : SHIFT;
      end

      SHIFT: begin
        if (!held) begin
          if (bus.s_valid) begin
            hold_byte_nxt = bus.s_data;
            held_last_nxt = bus.s_last;
            held_nxt      = 1'b1;
            dibit_cnt_nxt = 2'd0;
          end
        end else begin
          // Present bits [1:0] this cycle, then move the next pair down.
          hold_byte_nxt = {2'b00, hold_byte[7:2]};
          dibit_cnt_nxt = dibit_cnt + 2'd1;
          if (dibit_cnt == 2'd3) begin
            held_nxt     = 1'b0;
            byte_cnt_nxt = byte_cnt_inc;
            if (byte_cnt_inc == RATE_CNT) begin
              // Full block: never closed with serial_end. If this was also
              // the last byte, the padding needs a block of its own.
              state_nxt = WAIT_ACK;
              if (held_last) begin
                pad_pending_nxt = 1'b1;
              end
            end else if (held_last) begin
              state_nxt = END_BLK;
            end
          end
        end
      end

      END_BLK: begin
        final_nxt       = 1'b1;
        pad_pending_nxt = 1'b0;
        state_nxt       = WAIT_ACK;
      end

      WAIT_ACK: begin
        if (bus.acc_block_ready) begin
          if (final_q) begin
            msg_done_nxt = 1'b1;
            final_nxt    = 1'b0;
            state_nxt    = IDLE;
          end else begin
            // Either the next data block or the pending padding block;
            // START tells them apart using pad_pending.
            state_nxt = START;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decodes
  // -------------------------------------------------------------------------
  assign bus.s_ready     = (state == SHIFT) && !held;
  assign bus.enable_2bit = (state == SHIFT) && held;
  assign bus.serial_out  = bus.enable_2bit ? hold_byte[1:0] : 2'b00;
  assign bus.acc_start   = (state == START);
  assign bus.serial_end  = (state == END_BLK);
  assign bus.final_chunk = final_q;
  assign bus.msg_done    = msg_done_q;
  assign bus.busy        = (state != IDLE);
  assign dbg_state       = state;

endmodule

// File: tb/tb_shake_msg_serializer.sv
// ---------------------------------------------------------------------------
// tb_shake_msg_serializer
//
// Two serializer instances share one set of input drivers: dut_a with the
// SHAKE256 rate (136 bytes) and dut_b with a 4-byte rate so block boundaries
// are reachable quickly. sel_b selects which instance's outputs are observed.
// Each message is turned into an expected token stream (block start, dibits,
// block end, done) by a block-splitting model. The monitor pops one token per
// observed event.
// ---------------------------------------------------------------------------
module tb_shake_msg_serializer;

  localparam logic [3:0] TOK_START = 4'd4;
  localparam logic [3:0] TOK_END   = 4'd5;
  localparam logic [3:0] TOK_DONE  = 4'd6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       empty_msg;
  logic       ack_auto;
  logic       ack_manual;
  logic       ack_rand = 1'b0;
  logic       acc_block_ready;
  logic       sel_b;

  assign acc_block_ready = ack_auto ? ack_rand : ack_manual;

  always @(negedge clk) ack_rand = ($urandom_range(0, 2) == 0);

  shake_msg_serializer_if bus_a ();
  shake_msg_serializer_if bus_b ();
  logic [2:0] dbg_a;
  logic [2:0] dbg_b;

  assign bus_a.s_valid = s_valid;
  assign bus_a.s_data = s_data;
  assign bus_a.s_last = s_last;
  assign bus_a.empty_msg = empty_msg;
  assign bus_a.acc_block_ready = acc_block_ready;
  assign bus_b.s_valid = s_valid;
  assign bus_b.s_data = s_data;
  assign bus_b.s_last = s_last;
  assign bus_b.empty_msg = empty_msg;
  assign bus_b.acc_block_ready = acc_block_ready;

  shake_msg_serializer #(.RATE_BYTES(136)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_a),
    .dbg_state (dbg_a)
  );

  shake_msg_serializer #(.RATE_BYTES(4)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_b),
    .dbg_state (dbg_b)
  );

  // ---------------- observed outputs ----------------
  logic       o_s_ready, o_acc_start, o_enable, o_serial_end, o_final, o_done, o_busy;
  logic [1:0] o_serial_out;
  logic [2:0] o_dbg;
  assign o_s_ready    = sel_b ? bus_b.s_ready     : bus_a.s_ready;
  assign o_acc_start  = sel_b ? bus_b.acc_start   : bus_a.acc_start;
  assign o_enable     = sel_b ? bus_b.enable_2bit : bus_a.enable_2bit;
  assign o_serial_out = sel_b ? bus_b.serial_out  : bus_a.serial_out;
  assign o_serial_end = sel_b ? bus_b.serial_end  : bus_a.serial_end;
  assign o_final      = sel_b ? bus_b.final_chunk : bus_a.final_chunk;
  assign o_done       = sel_b ? bus_b.msg_done    : bus_a.msg_done;
  assign o_busy       = sel_b ? bus_b.busy        : bus_a.busy;
  assign o_dbg        = sel_b ? dbg_b             : dbg_a;

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_pass = 0;
  logic [3:0] exp_q[$];
  logic [7:0] msg_q[$];
  logic [1:0] dib_log[$];
  int         cnt_start, cnt_end, cnt_done;
  logic       mon_on = 1'b0;
  logic       prev_end = 1'b0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endfunction

  function automatic void tok(input logic [3:0] t);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL token_extra: got %0d, required no further event (t=%0t)", t, $time);
    end else begin
      e = exp_q.pop_front();
      check("token_order", 32'(t), 32'(e));
    end
  endfunction

  // Reference: bytes split into rate-sized blocks, four LSB-first dibits per
  // byte, a trailing padding-only block when the length is a multiple of
  // the rate (including zero), then one done event.
  function automatic void model_push(input int rate, input int len);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = msg_q[i];
      if (i % rate == 0) exp_q.push_back(TOK_START);
      for (int k = 0; k < 4; k++) exp_q.push_back(4'((b >> (2 * k)) & 8'h03));
    end
    if (len % rate == 0) exp_q.push_back(TOK_START);
    exp_q.push_back(TOK_END);
    exp_q.push_back(TOK_DONE);
  endfunction

  always @(negedge clk) begin
    if (mon_on && !reset) begin
      if (o_acc_start) begin
        tok(TOK_START);
        check("start_final_low", 32'(o_final), 0);
        cnt_start++;
      end
      if (o_enable) begin
        tok(4'(o_serial_out));
        check("dibit_final_low", 32'(o_final), 0);
        dib_log.push_back(o_serial_out);
      end else begin
        check("serial_out_idle_zero", 32'(o_serial_out), 0);
      end
      check("ready_while_held", 32'(o_s_ready && o_enable), 0);
      if (o_serial_end) begin
        tok(TOK_END);
        cnt_end++;
      end
      if (prev_end) check("final_after_end", 32'(o_final), 1);
      if (o_done) begin
        tok(TOK_DONE);
        check("done_final_clear", 32'(o_final), 0);
        cnt_done++;
      end
      prev_end = o_serial_end;
    end else begin
      prev_end = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    s_valid = 1'b0;
    s_data = 8'h00;
    s_last = 1'b0;
    empty_msg = 1'b0;
    ack_auto = 1'b0;
    ack_manual = 1'b0;
    mon_on = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Offers one byte, toggling s_valid randomly until it is taken.
  task automatic push_byte(input logic [7:0] d, input logic l);
    int guard = 0;
    s_valid = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    while (!(s_valid && o_s_ready) && guard < 500) begin
      @(negedge clk);
      s_valid = ($urandom_range(0, 1) == 1);
      guard++;
    end
    if (guard >= 500) begin
      n_checks++;
      $display("FAIL byte_accept_timeout: byte %0h not taken, required within 500 cycles", d);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_msg(input logic use_b, input int len);
    int guard = 0;
    exp_q.delete();
    dib_log.delete();
    cnt_start = 0;
    cnt_end = 0;
    cnt_done = 0;
    model_push(use_b ? 4 : 136, len);
    sel_b = use_b;
    mon_on = 1'b1;
    ack_auto = 1'b1;
    if (len == 0) begin
      empty_msg = 1'b1;
      @(negedge clk);
      empty_msg = 1'b0;
    end else begin
      for (int i = 0; i < len; i++) push_byte(msg_q[i], (i == len - 1));
    end
    while (cnt_done == 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("msg_done_seen", 32'(cnt_done != 0), 1);
    @(negedge clk);
    check("exp_queue_drained", 32'(exp_q.size()), 0);
    mon_on = 1'b0;
    ack_auto = 1'b0;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        use_b;
    int          len;
    logic [63:0] data;
    int          exp_start;
    int          exp_end;
    int          exp_dibits;
  } vec_t;

  vec_t vecs[7];
  int   exp0[12];

  initial begin
    #900000;
    $display("FAIL global_timeout: bench still running, required to finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    int g;
    logic [2:0] d0;

    vecs[0] = '{use_b: 1'b0, len: 3, data: 64'h0000_0000_0000_E41B, exp_start: 1, exp_end: 1, exp_dibits: 12};
    vecs[1] = '{use_b: 1'b1, len: 6, data: 64'h0000_6655_4433_2211, exp_start: 2, exp_end: 1, exp_dibits: 24};
    vecs[2] = '{use_b: 1'b1, len: 4, data: 64'h0000_0000_DEAD_BEEF, exp_start: 2, exp_end: 1, exp_dibits: 16};
    vecs[3] = '{use_b: 1'b1, len: 0, data: 64'h0, exp_start: 1, exp_end: 1, exp_dibits: 0};
    vecs[4] = '{use_b: 1'b1, len: 8, data: 64'h0123_4567_89AB_CDEF, exp_start: 3, exp_end: 1, exp_dibits: 32};
    vecs[5] = '{use_b: 1'b0, len: 1, data: 64'h0000_0000_0000_00FF, exp_start: 1, exp_end: 1, exp_dibits: 4};
    vecs[6] = '{use_b: 1'b1, len: 3, data: 64'h0000_0000_00C3_3C5A, exp_start: 1, exp_end: 1, exp_dibits: 12};
    exp0 = '{3, 2, 1, 0, 0, 1, 2, 3, 0, 0, 0, 0};

    sel_b = 1'b1;
    do_reset();

    // Reset values.
    check("rst_s_ready", 32'(o_s_ready), 0);
    check("rst_acc_start", 32'(o_acc_start), 0);
    check("rst_enable", 32'(o_enable), 0);
    check("rst_serial_out", 32'(o_serial_out), 0);
    check("rst_serial_end", 32'(o_serial_end), 0);
    check("rst_final", 32'(o_final), 0);
    check("rst_msg_done", 32'(o_done), 0);
    check("rst_busy", 32'(o_busy), 0);

    // Table-driven messages.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      msg_q.delete();
      for (int i = 0; i < vecs[v].len; i++) msg_q.push_back(vecs[v].data[8 * i +: 8]);
      send_msg(vecs[v].use_b, vecs[v].len);
      check("vec_start_count", 32'(cnt_start), 32'(vecs[v].exp_start));
      check("vec_end_count", 32'(cnt_end), 32'(vecs[v].exp_end));
      check("vec_dibit_count", 32'(dib_log.size()), 32'(vecs[v].exp_dibits));
      check("vec_done_count", 32'(cnt_done), 1);
      if (v == 0 && dib_log.size() == 12) begin
        for (int k = 0; k < 12; k++) check("vec0_dibit_seq", 32'(dib_log[k]), 32'(exp0[k]));
      end
    end

    // Randomized messages against the model.
    for (int r = 0; r < 12; r++) begin
      int len;
      logic ub;
      do_reset();
      len = $urandom_range(0, 9);
      ub = ($urandom_range(0, 3) != 0);
      msg_q.delete();
      for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
      send_msg(ub, len);
    end

    // Latency of a single-byte message, long accumulator stall, done timing.
    do_reset();
    sel_b = 1'b1;
    s_valid = 1'b1;
    s_data = 8'hA5;
    s_last = 1'b1;
    @(negedge clk);
    check("lat_acc_start", 32'(o_acc_start), 1);
    check("lat_ready_in_start", 32'(o_s_ready), 0);
    @(negedge clk);
    check("lat_start_one_cycle", 32'(o_acc_start), 0);
    check("lat_ready_in_shift", 32'(o_s_ready), 1);
    @(negedge clk);
    s_valid = 1'b0;
    check("lat_dibit0_en", 32'(o_enable), 1);
    check("lat_dibit0", 32'(o_serial_out), 1);
    check("lat_ready_held", 32'(o_s_ready), 0);
    @(negedge clk);
    check("lat_dibit1", 32'(o_serial_out), 1);
    @(negedge clk);
    check("lat_dibit2", 32'(o_serial_out), 2);
    @(negedge clk);
    check("lat_dibit3", 32'(o_serial_out), 2);
    @(negedge clk);
    check("lat_serial_end", 32'(o_serial_end), 1);
    check("lat_end_no_enable", 32'(o_enable), 0);
    @(negedge clk);
    check("lat_end_one_cycle", 32'(o_serial_end), 0);
    check("lat_final_set", 32'(o_final), 1);
    bad = 0;
    d0 = o_dbg;
    repeat (50) begin
      @(negedge clk);
      if (o_s_ready || o_acc_start || o_done || !o_busy || !o_final || o_dbg != d0) bad++;
    end
    check("wait_stall_50", 32'(bad), 0);
    ack_manual = 1'b1;
    @(negedge clk);
    ack_manual = 1'b0;
    check("ack_msg_done", 32'(o_done), 1);
    check("ack_busy_low", 32'(o_busy), 0);
    check("ack_final_clear", 32'(o_final), 0);
    @(negedge clk);
    check("msg_done_one_cycle", 32'(o_done), 0);

    // Zero-length message timing.
    do_reset();
    empty_msg = 1'b1;
    @(negedge clk);
    empty_msg = 1'b0;
    check("empty_acc_start", 32'(o_acc_start), 1);
    @(negedge clk);
    check("empty_serial_end", 32'(o_serial_end), 1);
    check("empty_no_enable", 32'(o_enable), 0);
    @(negedge clk);
    check("empty_final", 32'(o_final), 1);
    ack_manual = 1'b1;
    @(negedge clk);
    ack_manual = 1'b0;
    check("empty_msg_done", 32'(o_done), 1);

    // s_valid wins over a simultaneous empty_msg.
    do_reset();
    s_valid = 1'b1;
    s_data = 8'h3C;
    s_last = 1'b1;
    empty_msg = 1'b1;
    @(negedge clk);
    empty_msg = 1'b0;
    check("prio_acc_start", 32'(o_acc_start), 1);
    @(negedge clk);
    check("prio_shift_ready", 32'(o_s_ready), 1);
    check("prio_no_end", 32'(o_serial_end), 0);
    @(negedge clk);
    s_valid = 1'b0;
    check("prio_dibit0_en", 32'(o_enable), 1);
    check("prio_dibit0", 32'(o_serial_out), 0);

    // Message ending exactly on a block boundary: padding block timing.
    do_reset();
    for (int i = 0; i < 4; i++) push_byte(8'(8'h10 + i), (i == 3));
    g = 0;
    while (o_enable && g < 10) begin
      @(negedge clk);
      g++;
    end
    check("full_no_serial_end", 32'(o_serial_end), 0);
    check("full_not_final", 32'(o_final), 0);
    check("full_in_wait_ready_low", 32'(o_s_ready), 0);
    ack_manual = 1'b1;
    @(negedge clk);
    ack_manual = 1'b0;
    check("pad_acc_start", 32'(o_acc_start), 1);
    @(negedge clk);
    check("pad_serial_end", 32'(o_serial_end), 1);
    check("pad_no_enable", 32'(o_enable), 0);
    @(negedge clk);
    check("pad_final", 32'(o_final), 1);
    ack_manual = 1'b1;
    @(negedge clk);
    ack_manual = 1'b0;
    check("pad_msg_done", 32'(o_done), 1);

    // Reset asserted at the second dibit of a byte.
    do_reset();
    push_byte(8'h6C, 1'b1);
    @(negedge clk);
    check("mid_dibit1", 32'(o_serial_out), 3);
    reset = 1'b1;
    #1;
    check("mid_reset_outputs",
          32'({o_s_ready, o_acc_start, o_enable, o_serial_out, o_serial_end, o_final, o_done, o_busy}), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    msg_q.delete();
    msg_q.push_back(8'h1B);
    send_msg(1'b1, 1);
    check("after_reset_start_count", 32'(cnt_start), 1);
    if (dib_log.size() > 0) check("after_reset_first_dibit", 32'(dib_log[0]), 3);
    else check("after_reset_dibits_seen", 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
